tl_xbar_demux: RTL and testbench

Per-master A-channel demultiplexer for the TileLink crossbar. It steers one master's request stream to one of N_SLAVE per-slave output ports, and each port feeds that slave's arbiter stage. The target slave is chosen by an externally decoded index. The block keeps multi-beat bursts atomic and counts outstanding transactions so that a master never has requests in flight to two slaves at once, which keeps response order intact.

---
 rtl/tl_xbar_pkg.sv | 13 +
 rtl/tl_xbar_slice.sv | 62 ++++++
 rtl/tl_xbar_demux.sv | 108 ++++++++++
 tb/tb_tl_xbar_demux.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_xbar_pkg.sv
// Shared TileLink crossbar definitions: default sizing, select index type and
// assertion message strings used by the A-channel demultiplexer.
package tl_xbar_pkg;

  localparam int unsigned TL_XBAR_N_SLAVE   = 2;
  localparam int unsigned TL_XBAR_MAX_TRANS = 4;

  typedef logic [$clog2(TL_XBAR_N_SLAVE)-1:0] tl_xbar_sel_t;

  localparam string MSG_RSP_UNDERFLOW = "tl_xbar_demux: rsp_done_i with no outstanding transaction";
  localparam string MSG_CNT_OVERFLOW  = "tl_xbar_demux: transaction issued with counter at MAX_TRANS";

endpackage

// File: rtl/tl_xbar_slice.sv
// Two-entry valid/ready spill register: full throughput, one cycle latency and
// a fully registered ready towards the upstream side.
module tl_xbar_slice #(
  parameter type DATA_T = logic [0:0]
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  DATA_T in_data_i,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  output DATA_T out_data_o,
  output logic  out_valid_o,
  input  logic  out_ready_i
);

  DATA_T a_data_q, a_data_d, b_data_q, b_data_d;
  logic  a_full_q, a_full_d, b_full_q, b_full_d;
  logic  in_hs;

  assign in_ready_o  = !b_full_q;
  assign out_valid_o = a_full_q;
  assign out_data_o  = a_data_q;
  assign in_hs       = in_valid_i && !b_full_q;

  // Entry A faces the output; entry B only fills while A is stalled.
  always_comb begin
    a_full_d = a_full_q;
    a_data_d = a_data_q;
    b_full_d = b_full_q;
    b_data_d = b_data_q;
    if (!a_full_q || out_ready_i) begin
      if (b_full_q) begin
        a_full_d = 1'b1;
        a_data_d = b_data_q;
        b_full_d = 1'b0;
      end else begin
        a_full_d = in_hs;
        a_data_d = in_data_i;
      end
    end else if (in_hs) begin
      b_full_d = 1'b1;
      b_data_d = in_data_i;
    end
  end

  // NOTE: the payload registers are reset as well so a cleared slice never
  // exposes a stale beat, at the cost of reset fan-out on the data path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
    end
  end

endmodule

// File: rtl/tl_xbar_demux.sv
// Per-master A-channel demux: routes bursts atomically to one slave port and
// locks to that slave while transactions are outstanding. TL_XBAR_DEMUX_SLICE_EN adds output spill slices.
module tl_xbar_demux
  import tl_xbar_pkg::*;
#(
  parameter int unsigned N_SLAVE   = TL_XBAR_N_SLAVE,
  parameter type         DATA_T    = logic [0:0],
  parameter int unsigned MAX_TRANS = TL_XBAR_MAX_TRANS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  DATA_T                      inp_data_i,
  input  logic [$clog2(N_SLAVE)-1:0] inp_sel_i,
  input  logic                       inp_last_i,
  input  logic                       inp_valid_i,
  output logic                       inp_ready_o,
  output DATA_T [N_SLAVE-1:0]        oup_data_o,
  output logic  [N_SLAVE-1:0]        oup_valid_o,
  input  logic  [N_SLAVE-1:0]        oup_ready_i,
  input  logic                       rsp_done_i
);

  localparam int unsigned      SEL_W   = $clog2(N_SLAVE);
  localparam int unsigned      CNT_W   = $clog2(MAX_TRANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TRANS);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   lock_q, lock_d, tgt;
  logic               burst_q, burst_d;
  logic               issuable, hs, inc, dec;
  logic [N_SLAVE-1:0] port_valid, port_ready;

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so the block stays purely combinational with no latches.
  always_comb begin
    tgt         = (burst_q || cnt_q != '0) ? lock_q : inp_sel_i;
    issuable    = !rst_i && (burst_q || cnt_q == '0 ||
                             (inp_sel_i == lock_q && cnt_q < CNT_MAX));
    port_valid  = '0;
    inp_ready_o = 1'b0;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (tgt == SEL_W'(i)) begin
        port_valid[i] = issuable && inp_valid_i;
        inp_ready_o   = issuable && port_ready[i];
      end
    end
  end

  assign hs  = inp_valid_i && inp_ready_o;
  assign inc = hs && inp_last_i;
  assign dec = rsp_done_i && cnt_q != '0;

  always_comb begin
    burst_d = burst_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    if (hs) begin
      burst_d = !inp_last_i;
      if (!burst_q) lock_d = tgt;
    end
    if (inc && !dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (dec && !inc) cnt_d = cnt_q - CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      lock_q  <= '0;
      burst_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      burst_q <= burst_d;
    end
  end

`ifdef TL_XBAR_DEMUX_SLICE_EN
  for (genvar g = 0; g < N_SLAVE; g++) begin : g_slice
    tl_xbar_slice #(.DATA_T(DATA_T)) u_slice (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_data_i   (inp_data_i),
      .in_valid_i  (port_valid[g]),
      .in_ready_o  (port_ready[g]),
      .out_data_o  (oup_data_o[g]),
      .out_valid_o (oup_valid_o[g]),
      .out_ready_i (oup_ready_i[g])
    );
  end
`else
  assign oup_valid_o = port_valid;
  assign port_ready  = oup_ready_i;
  for (genvar g = 0; g < N_SLAVE; g++) begin : g_pass
    assign oup_data_o[g] = inp_data_i;
  end
`endif

  a_rsp_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_done_i && cnt_q == '0))
    else $error("%s", MSG_RSP_UNDERFLOW);

  a_cnt_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc && cnt_q == CNT_MAX))
    else $error("%s", MSG_CNT_OVERFLOW);

endmodule

// File: tb/tb_tl_xbar_demux.sv
// Scoreboard bench for tl_xbar_demux: directed scenarios then random traffic,
// checked against a transaction-level model of outstanding requests.
module tb_tl_xbar_demux;
  import tl_xbar_pkg::*;

  localparam int MAX_TRANS = TL_XBAR_MAX_TRANS;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [7:0]        inp_data_i;
  tl_xbar_sel_t      inp_sel_i;
  logic              inp_last_i;
  logic              inp_valid_i;
  logic              inp_ready_o;
  logic [1:0][7:0]   oup_data_o;
  logic [1:0]        oup_valid_o;
  logic [1:0]        oup_ready_i;
  logic              rsp_done_i;

  tl_xbar_demux #(
    .N_SLAVE   (2),
    .DATA_T    (logic [7:0]),
    .MAX_TRANS (MAX_TRANS)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inp_data_i  (inp_data_i),
    .inp_sel_i   (inp_sel_i),
    .inp_last_i  (inp_last_i),
    .inp_valid_i (inp_valid_i),
    .inp_ready_o (inp_ready_o),
    .oup_data_o  (oup_data_o),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .rsp_done_i  (rsp_done_i)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: slave ids of outstanding transactions, open-burst state,
  // and the per-port beats still owed by the DUT.
  int         outst[$];
  bit         in_burst = 1'b0;
  int         burst_tgt = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    outst.delete();
    exp_q0.delete();
    exp_q1.delete();
    in_burst = 1'b0;
  endtask

  // Drive one cycle of input, then evaluate the model at the falling edge.
  task automatic step(input bit v, input int sel, input bit last, input logic [7:0] d,
                      input bit rsp, output bit hs);
    bit allowed;
    int tgt;
    inp_valid_i = v;
    inp_sel_i   = tl_xbar_sel_t'(sel);
    inp_last_i  = last;
    inp_data_i  = d;
    rsp_done_i  = rsp;
    @(negedge clk_i);
    if (in_burst || outst.size() == 0) allowed = 1'b1;
    else allowed = (outst[0] == sel) && (outst.size() < MAX_TRANS);
    tgt = in_burst ? burst_tgt : sel;
    if (inp_valid_i && !allowed) check("stall_ready", inp_ready_o, 0);
`ifndef TL_XBAR_DEMUX_SLICE_EN
    if (inp_valid_i && allowed) begin
      check("route_valid", oup_valid_o, 32'(1 << tgt));
      check("route_ready", inp_ready_o, oup_ready_i[tgt]);
    end
`endif
    hs = inp_valid_i && inp_ready_o;
    if (hs) begin
      if (tgt == 0) exp_q0.push_back(d);
      else          exp_q1.push_back(d);
      if (!in_burst) burst_tgt = sel;
      in_burst = !last;
      if (last) outst.push_back(tgt);
    end
    if (rsp && outst.size() > 0) void'(outst.pop_front());
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_beat(input int sel, input bit last, input logic [7:0] d, input string nm);
    bit hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) step(1'b1, sel, last, d, 1'b0, hs);
    check(nm, hs, 1);
  endtask

  // Monitor: pops expected beats whenever a port handshakes and checks that a
  // stalled beat stays put.
  initial begin
    logic [1:0]      pend;
    logic [1:0][7:0] pend_data;
    logic [7:0]      exp_d;
    pend = '0;
    pend_data = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_i) begin
        pend = '0;
        continue;
      end
      check("valid_onehot0", 32'($onehot0(oup_valid_o)), 1);
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          check($sformatf("hold_valid_p%0d", p), oup_valid_o[p], 1);
          check($sformatf("hold_data_p%0d", p), oup_data_o[p], pend_data[p]);
        end
        if (oup_valid_o[p] && oup_ready_i[p]) begin
          if (p == 0) begin
            check("beat_expected_p0", exp_q0.size() != 0, 1);
            if (exp_q0.size() != 0) begin
              exp_d = exp_q0.pop_front();
              check("beat_data_p0", oup_data_o[0], exp_d);
            end
          end else begin
            check("beat_expected_p1", exp_q1.size() != 0, 1);
            if (exp_q1.size() != 0) begin
              exp_d = exp_q1.pop_front();
              check("beat_data_p1", oup_data_o[1], exp_d);
            end
          end
        end
        pend[p]      = oup_valid_o[p] && !oup_ready_i[p];
        pend_data[p] = oup_data_o[p];
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit hs;
    bit pend;
    bit first;
    bit cur_last;
    int rem;
    int cur_sel;
    logic [7:0] cur_d;

    rst_i       = 1'b1;
    inp_valid_i = 1'b1;
    inp_sel_i   = 1'b1;
    inp_last_i  = 1'b1;
    inp_data_i  = 8'hA5;
    rsp_done_i  = 1'b0;
    oup_ready_i = 2'b11;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_oup_valid", oup_valid_o, 0);
    check("rst_inp_ready", inp_ready_o, 0);
    rst_i = 1'b0;
    inp_valid_i = 1'b0;

    // Fill to MAX_TRANS on slave 1, then one response releases the next.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 8'h10 + 8'(i), 0, hs);
      check("t1_issue", hs, 1);
    end
    step(1, 1, 1, 8'h14, 0, hs); check("t1_stall", hs, 0);
    step(1, 1, 1, 8'h14, 1, hs); check("t1_stall_rsp", hs, 0);
    step(1, 1, 1, 8'h14, 0, hs); check("t1_release", hs, 1);
    repeat (2) step(0, 0, 1, 8'h00, 1, hs);

    // Switching slave waits for the two outstanding transactions to retire.
    step(1, 0, 1, 8'h20, 0, hs); check("t2_stall", hs, 0);
    step(1, 0, 1, 8'h20, 1, hs); check("t2_stall_rsp1", hs, 0);
    step(1, 0, 1, 8'h20, 1, hs); check("t2_stall_rsp2", hs, 0);
    step(1, 0, 1, 8'h20, 0, hs); check("t2_issue", hs, 1);
    step(0, 0, 1, 8'h00, 1, hs);

    // Burst to slave 1 with sel flipped on continuation beats.
    step(1, 1, 0, 8'h30, 0, hs); check("t3_beat1", hs, 1);
    step(1, 0, 0, 8'h31, 0, hs); check("t3_beat2", hs, 1);
    step(1, 0, 0, 8'h32, 0, hs); check("t3_beat3", hs, 1);
    step(1, 0, 1, 8'h33, 0, hs); check("t3_beat4", hs, 1);

    // Slave 1 back-pressure for three cycles mid-burst.
    step(1, 1, 0, 8'h40, 0, hs); check("t4_beat1", hs, 1);
    oup_ready_i[1] = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk_i);
        #1;
        oup_ready_i[1] = 1'b1;
      end
    join_none
    send_beat(0, 0, 8'h41, "t4_beat2");
    send_beat(0, 0, 8'h42, "t4_beat3");
    send_beat(1, 1, 8'h43, "t4_beat4");

    // Issue and retire in the same cycle at two outstanding: count stays 2.
    step(1, 1, 1, 8'h50, 1, hs); check("t5_issue_rsp", hs, 1);
    step(1, 1, 1, 8'h51, 0, hs); check("t5_fill3", hs, 1);
    step(1, 1, 1, 8'h52, 0, hs); check("t5_fill4", hs, 1);
    step(1, 1, 1, 8'h53, 0, hs); check("t5_full", hs, 0);
    step(1, 1, 1, 8'h53, 1, hs); check("t5_full_rsp", hs, 0);
    step(1, 1, 1, 8'h53, 0, hs); check("t5_release", hs, 1);
    repeat (4) step(0, 0, 1, 8'h00, 1, hs);

    // Asynchronous reset in the middle of a burst.
    step(1, 1, 0, 8'h60, 0, hs); check("t6_beat1", hs, 1);
    inp_valid_i = 1'b1;
    inp_sel_i   = 1'b1;
    inp_last_i  = 1'b0;
    inp_data_i  = 8'h61;
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_oup_valid", oup_valid_o, 0);
    check("t6_rst_inp_ready", inp_ready_o, 0);
    model_reset();
    inp_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step(1, 0, 1, 8'h62, 0, hs); check("t6_after_rst", hs, 1);
    step(0, 0, 1, 8'h00, 1, hs);

    // Random traffic: bursts of 1..4 beats, random back-pressure and responses.
    pend = 1'b0;
    first = 1'b0;
    rem = 0;
    cur_sel = 0;
    cur_last = 1'b0;
    cur_d = '0;
    for (int c = 0; c < 4000; c++) begin
      if (c >= 3000 && !pend && rem == 0) break;
      if (!pend) begin
        if (rem == 0 && c < 3000 && $urandom_range(0, 3) != 0) begin
          rem = $urandom_range(1, 4);
          cur_sel = $urandom_range(0, 1);
          first = 1'b1;
        end
        if (rem != 0 && $urandom_range(0, 4) != 0) begin
          pend = 1'b1;
          cur_last = (rem == 1);
          cur_d = 8'($urandom);
          if (!first) cur_sel = $urandom_range(0, 1);
          first = 1'b0;
        end
      end
      oup_ready_i = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      step(pend, cur_sel, cur_last, cur_d,
           outst.size() > 0 && $urandom_range(0, 2) == 0, hs);
      if (hs) begin
        pend = 1'b0;
        rem--;
      end
    end
    check("rand_complete", 32'(pend || rem != 0), 0);

    oup_ready_i = 2'b11;
    while (outst.size() > 0) step(0, 0, 1, 8'h00, 1, hs);
    repeat (8) step(0, 0, 1, 8'h00, 0, hs);
    check("drain_p0", exp_q0.size(), 0);
    check("drain_p1", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
